sound_arbiter: RTL

Shares the single note-sound unit between three note sources in study mode:
- live key hits,
- song guide autoplay,
- record replay.

The block arbitrates requests, latches the winning octave/note/length and issues one start pulse. It then waits for the sound unit's `over` pulse, inserts an inter-note gap and returns completion to the owner. A watchdog releases the unit if `over` never arrives. It sits between the mode controllers and the sound unit.

---
 rtl/sound_arbiter_pkg.sv | 32 +++
 rtl/sound_arbiter_if.sv | 42 ++++
 rtl/sound_arbiter_rr_pick2.sv | 18 +
 rtl/sound_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_arbiter_pkg.sv
// Shared definitions for the sound arbiter: source indices, FSM states,
// default field widths and a one-hot helper.
`timescale 1ns/1ps
package sound_arbiter_pkg;

  localparam int NUM_SRC    = 3;
  localparam int DEF_OCT_W  = 2;
  localparam int DEF_NOTE_W = 3;
  localparam int DEF_LEN_W  = 3;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_LIVE = 2'd0;
  localparam src_idx_t SRC_SONG = 2'd1;
  localparam src_idx_t SRC_REC  = 2'd2;
  localparam src_idx_t SRC_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // One-hot source vector; SRC_NONE maps to all zeros
  function automatic logic [NUM_SRC-1:0] src_onehot(input src_idx_t idx);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    if (idx != SRC_NONE) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// Bundle between the mode controllers / sound unit side and the arbiter.
// The arbiter connects through the slave modport; the environment that
// drives requests and the sound unit's over pulse uses the master modport.
`timescale 1ns/1ps
interface sound_arbiter_if
  import sound_arbiter_pkg::*;
#(
  parameter int OCT_W  = DEF_OCT_W,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*OCT_W-1:0]  req_oct;
  logic [NUM_SRC*NOTE_W-1:0] req_note;
  logic [NUM_SRC*LEN_W-1:0]  req_len;
  logic [NUM_SRC-1:0]        gnt;
  logic [NUM_SRC-1:0]        done;
  logic                      done_abort;
  logic                      snd_start;
  logic                      snd_abort;
  logic [OCT_W-1:0]          snd_oct;
  logic [NOTE_W-1:0]         snd_note;
  logic [LEN_W-1:0]          snd_len;
  logic                      snd_over;
  logic                      busy;
  src_idx_t                  owner;
  logic                      timeout_err;

  modport slave (
    input  req, req_oct, req_note, req_len, snd_over,
    output gnt, done, done_abort, snd_start, snd_abort,
           snd_oct, snd_note, snd_len, busy, owner, timeout_err
  );

  modport master (
    output req, req_oct, req_note, req_len, snd_over,
    input  gnt, done, done_abort, snd_start, snd_abort,
           snd_oct, snd_note, snd_len, busy, owner, timeout_err
  );

endinterface

// File: rtl/sound_arbiter_rr_pick2.sv
// Combinational round-robin pick between the song and record sources.
// rr = 0 means song is preferred when both request, rr = 1 prefers record.
`timescale 1ns/1ps
module rr_pick2 (
  input  logic req_song,
  input  logic req_rec,
  input  logic rr,
  output logic pick_valid,
  output logic pick_rec
);

  // Record wins if it is alone or if it holds the round-robin turn
  always_comb begin
    pick_valid = req_song | req_rec;
    pick_rec   = req_rec & (~req_song | rr);
  end

endmodule

// File: rtl/sound_arbiter.sv
// Shares one note-sound unit between live keys, song autoplay and record
// replay. Live has fixed top priority, song/record alternate round-robin.
// A granted note is latched, started, and held until the sound unit reports
// over (or the watchdog gives up), followed by an optional silent gap.
// Optional feature: define LIVE_PREEMPT_EN to let a live request abort a
// song or record note in progress and take the unit immediately.
`timescale 1ns/1ps
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int OCT_W           = DEF_OCT_W,
  parameter int NOTE_W          = DEF_NOTE_W,
  parameter int LEN_W           = DEF_LEN_W,
  parameter int GAP_CYCLES      = 16,
  parameter int MAX_NOTE_CYCLES = 2**24
) (
  input  logic           clk,
  input  logic           rst,
  sound_arbiter_if.slave bus
);

  localparam int WD_W  = $clog2(MAX_NOTE_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_NOTE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  arb_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  gnt_q, gnt_d;
  logic [NUM_SRC-1:0]  done_q, done_d;
  logic                done_abort_q, done_abort_d;
  logic                snd_start_q, snd_start_d;
  logic                snd_abort_q, snd_abort_d;
  logic [OCT_W-1:0]    snd_oct_q, snd_oct_d;
  logic [NOTE_W-1:0]   snd_note_q, snd_note_d;
  logic [LEN_W-1:0]    snd_len_q, snd_len_d;
  src_idx_t            owner_q, owner_d;
  logic                rr_q, rr_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic                pick_valid;
  logic                pick_rec;
  logic                win_valid;
  src_idx_t            win_idx;
  logic [OCT_W-1:0]    win_oct;
  logic [NOTE_W-1:0]   win_note;
  logic [LEN_W-1:0]    win_len;
  logic                over_hit;
  logic                timeout_hit;
  logic                preempt_hit;
  logic                gap_done;

  rr_pick2 u_rr_pick2 (
    .req_song   (bus.req[SRC_SONG]),
    .req_rec    (bus.req[SRC_REC]),
    .rr         (rr_q),
    .pick_valid (pick_valid),
    .pick_rec   (pick_rec)
  );

  // Winner selection: live first, otherwise the round-robin pick, plus its fields
  always_comb begin
    win_valid = 1'b0;
    win_idx   = SRC_NONE;
    if (bus.req[SRC_LIVE]) begin
      win_valid = 1'b1;
      win_idx   = SRC_LIVE;
    end else if (pick_valid) begin
      win_valid = 1'b1;
      win_idx   = pick_rec ? SRC_REC : SRC_SONG;
    end
    win_oct  = bus.req_oct[0 +: OCT_W];
    win_note = bus.req_note[0 +: NOTE_W];
    win_len  = bus.req_len[0 +: LEN_W];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (win_idx == src_idx_t'(i)) begin
        win_oct  = bus.req_oct[i*OCT_W +: OCT_W];
        win_note = bus.req_note[i*NOTE_W +: NOTE_W];
        win_len  = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign over_hit    = bus.snd_over;
  assign timeout_hit = (wd_cnt_q == WD_LAST);
  assign gap_done    = (gap_cnt_q == GAP_LAST);

`ifdef LIVE_PREEMPT_EN
  assign preempt_hit = bus.req[SRC_LIVE] && (owner_q != SRC_LIVE);
`else
  assign preempt_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: grant in IDLE, note end in PLAY, countdown in GAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (over_hit)         state_d = HAS_GAP ? ST_GAP : ST_IDLE;
        else if (preempt_hit) state_d = ST_IDLE;
        else if (timeout_hit) state_d = HAS_GAP ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, latched fields hold
  always_comb begin
    gnt_d         = '0;
    done_d        = '0;
    done_abort_d  = 1'b0;
    snd_start_d   = 1'b0;
    snd_abort_d   = 1'b0;
    snd_oct_d     = snd_oct_q;
    snd_note_d    = snd_note_q;
    snd_len_d     = snd_len_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    wd_cnt_d      = wd_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          gnt_d       = src_onehot(win_idx);
          snd_start_d = 1'b1;
          snd_oct_d   = win_oct;
          snd_note_d  = win_note;
          snd_len_d   = win_len;
          owner_d     = win_idx;
          wd_cnt_d    = '0;
          if (win_idx == SRC_SONG) rr_d = 1'b1;
          if (win_idx == SRC_REC)  rr_d = 1'b0;
        end
      end
      ST_PLAY: begin
        wd_cnt_d  = wd_cnt_q + 1'b1;
        gap_cnt_d = '0;
        if (over_hit) begin
          done_d  = src_onehot(owner_q);
          owner_d = SRC_NONE;
        end else if (preempt_hit) begin
          done_d       = src_onehot(owner_q);
          done_abort_d = 1'b1;
          snd_abort_d  = 1'b1;
          owner_d      = SRC_NONE;
        end else if (timeout_hit) begin
          done_d        = src_onehot(owner_q);
          done_abort_d  = 1'b1;
          snd_abort_d   = 1'b1;
          timeout_err_d = 1'b1;
          owner_d       = SRC_NONE;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        owner_d   = SRC_NONE;
      end
      default: begin
        owner_d = SRC_NONE;
      end
    endcase
  end

  // Output, field and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q         <= '0;
      done_q        <= '0;
      done_abort_q  <= 1'b0;
      snd_start_q   <= 1'b0;
      snd_abort_q   <= 1'b0;
      snd_oct_q     <= '0;
      snd_note_q    <= '0;
      snd_len_q     <= '0;
      owner_q       <= SRC_NONE;
      rr_q          <= 1'b0;
      wd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      done_abort_q  <= done_abort_d;
      snd_start_q   <= snd_start_d;
      snd_abort_q   <= snd_abort_d;
      snd_oct_q     <= snd_oct_d;
      snd_note_q    <= snd_note_d;
      snd_len_q     <= snd_len_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      wd_cnt_q      <= wd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.done_abort  = done_abort_q;
  assign bus.snd_start   = snd_start_q;
  assign bus.snd_abort   = snd_abort_q;
  assign bus.snd_oct     = snd_oct_q;
  assign bus.snd_note    = snd_note_q;
  assign bus.snd_len     = snd_len_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.owner       = owner_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
